set_job_master: RTL and testbench

//  Initiator side of the SET circle-counting job interface. Fetches job words (central, radius, mode, expected)

---
 rtl/set_job_master_pkg.sv | 24 ++
 rtl/set_job_master_if.sv | 22 ++
 rtl/set_job_master_watchdog.sv | 18 +
 rtl/set_job_master.sv | 122 ++++++++++++
 tb/tb_set_job_master.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/set_job_master_pkg.sv
// set_job_master_pkg: job word layout, SET mode encodings and sequencer state enum
package set_job_master_pkg;
   typedef enum logic [1:0] {
      MODE_A      = 2'd0,
      MODE_A_AND_B = 2'd1,
      MODE_A_XOR_B = 2'd2,
      MODE_TWO_OF  = 2'd3
   } mode_e;
   typedef struct packed {
      logic [23:0] central;
      logic [11:0] radius;
      mode_e       mode;
      logic [7:0]  expected;
   } job_t;
   localparam int JOB_W = $bits(job_t);
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_e;
endpackage

// File: rtl/set_job_master_if.sv
// set_job_master_if: job memory read port plus SET engine job/result handshake
interface set_job_master_if #(
   parameter int ADDR_W = 6
);
   logic [ADDR_W-1:0]                    job_addr;
   logic [set_job_master_pkg::JOB_W-1:0] job_data;
   logic                                 en;
   logic [23:0]                          central;
   logic [11:0]                          radius;
   logic [1:0]                           mode;
   logic                                 busy;
   logic                                 valid;
   logic [7:0]                           candidate;
   modport master (
      output job_addr, en, central, radius, mode,
      input  job_data, busy, valid, candidate
   );
   modport slave (
      input  job_addr, en, central, radius, mode,
      output job_data, busy, valid, candidate
   );
endinterface

// File: rtl/set_job_master_watchdog.sv
// set_job_master_watchdog: cycle counter that flags expiry on its TIMEOUT-th counted cycle
module set_job_master_watchdog #(
   parameter int TIMEOUT = 512
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic run,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT);
   logic [W-1:0] cnt;
   // restart from zero on load, advance only while the owner is waiting
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= load ? '0 : run ? cnt + W'(1) : cnt;
   assign expired = cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/set_job_master.sv
// set_job_master: fetches jobs, drives a SET engine, tallies pass/fail; SET_JOB_MISMATCH_LOG_EN adds first-mismatch log
module set_job_master
   import set_job_master_pkg::*;
#(
   parameter int ADDR_W  = 6,
   parameter int TIMEOUT = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   job_count,
   set_job_master_if.master  bus,
   output logic              running,
   output logic              done,
   output logic [ADDR_W:0]   pass_cnt,
   output logic [ADDR_W:0]   fail_cnt,
   output logic              timeout_err
`ifdef SET_JOB_MISMATCH_LOG_EN
   ,
   output logic [ADDR_W-1:0] first_fail_idx,
   output logic [7:0]        first_fail_got,
   output logic [7:0]        first_fail_exp,
   output logic              first_fail_vld
`endif
);
   state_e            st, nxt;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W:0]   cnt_q;
   logic [7:0]        exp_q, cand_q;
   logic              accept, issue, got, tmo, check, last, match, expired;
   job_t              job;
   assign job     = job_t'(bus.job_data);
   assign accept  = st == S_IDLE && start;
   assign issue   = st == S_ISSUE && !bus.busy;
   assign got     = st == S_WAIT && bus.valid;
   assign tmo     = st == S_WAIT && !bus.valid && expired;
   assign check   = st == S_CHECK;
   assign last    = ({1'b0, idx} + (ADDR_W + 1)'(1)) == cnt_q;
   assign match   = cand_q == exp_q;
   assign running = st != S_IDLE;
   assign done    = st == S_DONE;
   assign bus.job_addr = idx;
   set_job_master_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .load    (issue),
      .run     (st == S_WAIT),
      .expired (expired)
   );
   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) st <= S_IDLE;
      else st <= nxt;
   // next-state: one job walks FETCH, ISSUE, WAIT, CHECK; timeout aborts the batch
   always_comb begin
      nxt = st;
      case (st)
         S_IDLE:  nxt = !start ? S_IDLE : job_count == '0 ? S_DONE : S_FETCH;
         S_FETCH: nxt = S_ISSUE;
         S_ISSUE: nxt = bus.busy ? S_ISSUE : S_WAIT;
         S_WAIT:  nxt = bus.valid ? S_CHECK : expired ? S_DONE : S_WAIT;
         S_CHECK: nxt = last ? S_DONE : S_FETCH;
         S_DONE:  nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end
   // job latch, SET strobe and result tally
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         idx         <= '0;
         cnt_q       <= '0;
         exp_q       <= '0;
         cand_q      <= '0;
         pass_cnt    <= '0;
         fail_cnt    <= '0;
         timeout_err <= 1'b0;
         bus.en      <= 1'b0;
         bus.central <= '0;
         bus.radius  <= '0;
         bus.mode    <= '0;
      end else begin
         bus.en <= issue;
         if (accept) begin
            idx         <= '0;
            cnt_q       <= job_count;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            timeout_err <= 1'b0;
         end
         if (issue) begin
            bus.central <= job.central;
            bus.radius  <= job.radius;
            bus.mode    <= job.mode;
            exp_q       <= job.expected;
         end
         if (got) cand_q <= bus.candidate;
         if (check) begin
            pass_cnt <= match ? pass_cnt + (ADDR_W + 1)'(1) : pass_cnt;
            fail_cnt <= match ? fail_cnt : fail_cnt + (ADDR_W + 1)'(1);
            if (!last) idx <= idx + ADDR_W'(1);
         end
         if (tmo) begin
            timeout_err <= 1'b1;
            fail_cnt    <= fail_cnt + (ADDR_W + 1)'(1);
         end
      end
`ifdef SET_JOB_MISMATCH_LOG_EN
   // capture the first candidate/expected mismatch of the batch
   always_ff @(posedge clk or posedge rst)
      if (rst || accept) begin
         first_fail_idx <= '0;
         first_fail_got <= '0;
         first_fail_exp <= '0;
         first_fail_vld <= 1'b0;
      end else if (check && !match && !first_fail_vld) begin
         first_fail_idx <= idx;
         first_fail_got <= cand_q;
         first_fail_exp <= exp_q;
         first_fail_vld <= 1'b1;
      end
`endif
endmodule

// File: tb/tb_set_job_master.sv
// tb_set_job_master: directed batches against a SET model with a job scoreboard
module tb_set_job_master;
   localparam int ADDR_W  = 6;
   localparam int TIMEOUT = 512;
   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W:0]   job_count = '0;
   logic              running, done, timeout_err;
   logic [ADDR_W:0]   pass_cnt, fail_cnt;
`ifdef SET_JOB_MISMATCH_LOG_EN
   logic [ADDR_W-1:0] first_fail_idx;
   logic [7:0]        first_fail_got, first_fail_exp;
   logic              first_fail_vld;
`endif
   set_job_master_if #(.ADDR_W(ADDR_W)) bus();
   logic        set_busy = 1'b0, ext_busy = 1'b0, set_mute = 1'b0;
   int          set_lat = 3, lat = 0;
   logic [7:0]  pend = '0;
   logic [45:0] mem [64];
   logic [37:0] sb_q [$];
   logic [7:0]  res_q [$];
   int n_chk = 0, n_fail = 0, en_cnt = 0, done_cnt = 0, cyc = 0, en_cyc = 0, done_cyc = 0;
   int exp_pass = 0, exp_fail = 0, e0, d0;
   logic [7:0]  log_got, log_exp;
   assign bus.busy = set_busy | ext_busy;
   always #5 clk = ~clk;
   set_job_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .job_count   (job_count),
      .bus         (bus),
      .running     (running),
      .done        (done),
      .pass_cnt    (pass_cnt),
      .fail_cnt    (fail_cnt),
      .timeout_err (timeout_err)
`ifdef SET_JOB_MISMATCH_LOG_EN
      ,
      .first_fail_idx (first_fail_idx),
      .first_fail_got (first_fail_got),
      .first_fail_exp (first_fail_exp),
      .first_fail_vld (first_fail_vld)
`endif
   );
   always @(posedge clk) bus.job_data <= mem[bus.job_addr];
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   // monitor en/done, score each issued job, and model the SET engine
   always @(negedge clk) begin
      cyc++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus.en) begin
         en_cnt++;
         en_cyc = cyc;
         chk("sb_job", {1'b0, bus.central, bus.radius, bus.mode},
             sb_q.size() > 0 ? {1'b0, sb_q.pop_front()} : {1'b1, 38'h0});
      end
      if (rst) begin
         set_busy = 1'b0;
         bus.valid = 1'b0;
         bus.candidate = '0;
      end else if (bus.valid) begin
         bus.valid = 1'b0;
         set_busy = 1'b0;
      end else if (bus.en) begin
         set_busy = 1'b1;
         lat = set_lat;
         pend = res_q.size() > 0 ? res_q.pop_front() : 8'h00;
      end else if (set_busy && !set_mute) begin
         if (lat == 0) begin
            bus.valid = 1'b1;
            bus.candidate = pend;
         end else lat--;
      end
   end
   task automatic tick();
      @(negedge clk);
      #1;
   endtask
   task automatic clear_exp();
      exp_pass = 0;
      exp_fail = 0;
   endtask
   task automatic load_job(input int i, input logic [23:0] c, input logic [11:0] r,
                           input logic [1:0] m, input logic [7:0] e, input logic [7:0] res);
      mem[i] = {c, r, m, e};
      sb_q.push_back({c, r, m});
      res_q.push_back(res);
      if (res == e) exp_pass++;
      else exp_fail++;
   endtask
   task automatic run(input int n, input int max, input string tag);
      int d;
      d = done_cnt;
      job_count = (ADDR_W + 1)'(n);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < max && done_cnt == d; i++) tick();
      tick();
      tick();
      chk({tag, "_one_done"}, done_cnt - d, 1);
      chk({tag, "_idle"}, running, 0);
   endtask
   initial begin
      tick();
      tick();
      chk("rst_running", running, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass_cnt, 0);
      chk("rst_fail", fail_cnt, 0);
      chk("rst_tmo", timeout_err, 0);
      chk("rst_en", bus.en, 0);
      chk("rst_job_out", {bus.central, bus.radius, bus.mode}, 0);
      chk("rst_addr", bus.job_addr, 0);
      rst = 1'b0;
      tick();
      // single passing job
      clear_exp();
      load_job(0, {4'd4, 4'd4, 16'd0}, {4'd3, 8'd0}, 2'd0, 8'd29, 8'd29);
      e0 = en_cnt;
      run(1, 100, "t1");
      chk("t1_pass", pass_cnt, exp_pass);
      chk("t1_fail", fail_cnt, exp_fail);
      chk("t1_en", en_cnt - e0, 1);
      // same job, expected count off by one
      clear_exp();
      load_job(0, {4'd4, 4'd4, 16'd0}, {4'd3, 8'd0}, 2'd0, 8'd28, 8'd29);
      run(1, 100, "t2");
      chk("t2_pass", pass_cnt, exp_pass);
      chk("t2_fail", fail_cnt, exp_fail);
`ifdef SET_JOB_MISMATCH_LOG_EN
      chk("t2_log", {first_fail_vld, first_fail_idx, first_fail_got, first_fail_exp},
          {1'b1, 6'd0, 8'd29, 8'd28});
`endif
      // empty batch
      e0 = en_cnt;
      d0 = done_cnt;
      job_count = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t3_done_hi", done, 1);
      chk("t3_running_hi", running, 1);
      tick();
      chk("t3_done_lo", done, 0);
      chk("t3_running_lo", running, 0);
      chk("t3_counts", {pass_cnt, fail_cnt}, 0);
      chk("t3_no_en", en_cnt - e0, 0);
      chk("t3_one_done", done_cnt - d0, 1);
      // engine never answers
      set_mute = 1'b1;
      clear_exp();
      load_job(0, 24'h123456, 12'h321, 2'd2, 8'd5, 8'd5);
      run(1, 700, "t4");
      chk("t4_tmo", timeout_err, 1);
      chk("t4_fail", fail_cnt, 1);
      chk("t4_pass", pass_cnt, 0);
      chk("t4_wait_len", done_cyc - en_cyc, TIMEOUT);
      // late answer arrives while idle and must be ignored
      set_mute = 1'b0;
      repeat (10) tick();
      chk("t4_late_valid", {timeout_err, pass_cnt, fail_cnt}, {1'b1, 7'd0, 7'd1});
      // engine busy after fetch
      clear_exp();
      load_job(0, 24'hABCDEF, 12'h456, 2'd1, 8'd7, 8'd7);
      ext_busy = 1'b1;
      e0 = en_cnt;
      d0 = done_cnt;
      job_count = 7'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (12) tick();
      chk("t5_no_en_busy", en_cnt - e0, 0);
      chk("t5_running", running, 1);
      chk("t5_tmo_cleared", timeout_err, 0);
      ext_busy = 1'b0;
      for (int i = 0; i < 100 && done_cnt == d0; i++) tick();
      tick();
      chk("t5_one_en", en_cnt - e0, 1);
      chk("t5_one_done", done_cnt - d0, 1);
      chk("t5_pass", pass_cnt, exp_pass);
      // reset in the middle of an 8-job batch
      set_lat = 20;
      clear_exp();
      for (int i = 0; i < 8; i++)
         load_job(i, 24'($urandom), 12'($urandom), 2'($urandom), 8'(i * 11), 8'(i * 11));
      e0 = en_cnt;
      job_count = 7'd8;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 500 && en_cnt - e0 < 3; i++) tick();
      chk("t6_reach_job3", en_cnt - e0, 3);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      chk("t6_rst_status", {running, done, timeout_err, pass_cnt, fail_cnt}, 0);
      chk("t6_rst_job_out", {bus.en, bus.central, bus.radius, bus.mode}, 0);
      chk("t6_rst_addr", bus.job_addr, 0);
      rst = 1'b0;
      sb_q.delete();
      res_q.delete();
      set_lat = 2;
      tick();
      // clean rerun with mismatches at jobs 2 and 5
      clear_exp();
      for (int i = 0; i < 8; i++) begin
         logic [7:0] e, r;
         e = 8'($urandom);
         r = (i % 3 == 2) ? e ^ 8'h5A : e;
         if (i == 2) begin
            log_got = r;
            log_exp = e;
         end
         load_job(i, 24'($urandom), 12'($urandom), 2'(i), e, r);
      end
      e0 = en_cnt;
      run(8, 1000, "t6");
      chk("t6_pass", pass_cnt, exp_pass);
      chk("t6_fail", fail_cnt, exp_fail);
      chk("t6_en", en_cnt - e0, 8);
      chk("t6_sb_empty", sb_q.size(), 0);
      chk("t6_tmo", timeout_err, 0);
`ifdef SET_JOB_MISMATCH_LOG_EN
      chk("t6_log", {first_fail_vld, first_fail_idx, first_fail_got, first_fail_exp},
          {1'b1, 6'd2, log_got, log_exp});
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
